// File: rtl/darkmemarb_pkg.sv
// Shared types and constants for the darkriscv two-port to one-port memory arbiter.
// Supports data widths up to ARB_MAX_DW bits.
package darkmemarb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_gnt_t;

  localparam int ARB_CNT_W  = 16;
  localparam int ARB_MAX_DW = 256;

  // Returned to the requester when the slave never answers.
  localparam logic [ARB_MAX_DW-1:0] ARB_ABORT_DATA = '1;

  // The watchdog holds at its maximum value rather than wrapping.
  function automatic logic [ARB_CNT_W-1:0] sat_inc(input logic [ARB_CNT_W-1:0] v);
    return (v == '1) ? v : v + ARB_CNT_W'(1);
  endfunction

endpackage

// File: rtl/darkmemarb_if.sv
// Bus bundle for darkmemarb: instruction port, data port and the shared memory port.
// The master side holds the core requesters and the memory slave; the arbiter uses the slave side.
interface darkmemarb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // Request/acknowledge: a requester raises its request (I_REQ, D_RD or D_WR) with a stable
  // address/command and holds it until the matching one-cycle ACK, where the data is valid.
  // The arbiter holds M_REQ and a stable command until the cycle after M_ACK (or an abort);
  // M_RDATA is sampled only while M_ACK=1 and M_ACK is ignored when no access is outstanding.
  logic            I_REQ;
  logic [AW-1:0]   I_ADDR;
  logic [DW-1:0]   I_DATA;
  logic            I_ACK;

  logic            D_RD;
  logic            D_WR;
  logic [DW/8-1:0] D_BE;
  logic [AW-1:0]   D_ADDR;
  logic [DW-1:0]   D_WDATA;
  logic [DW-1:0]   D_RDATA;
  logic            D_ACK;

  logic            M_REQ;
  logic            M_WE;
  logic [DW/8-1:0] M_BE;
  logic [AW-1:0]   M_ADDR;
  logic [DW-1:0]   M_WDATA;
  logic [DW-1:0]   M_RDATA;
  logic            M_ACK;

  logic            HLT;
  logic            ERR;

  modport master (
    output I_REQ, I_ADDR, D_RD, D_WR, D_BE, D_ADDR, D_WDATA, M_RDATA, M_ACK,
    input  I_DATA, I_ACK, D_RDATA, D_ACK, M_REQ, M_WE, M_BE, M_ADDR, M_WDATA, HLT, ERR
  );

  modport slave (
    input  I_REQ, I_ADDR, D_RD, D_WR, D_BE, D_ADDR, D_WDATA, M_RDATA, M_ACK,
    output I_DATA, I_ACK, D_RDATA, D_ACK, M_REQ, M_WE, M_BE, M_ADDR, M_WDATA, HLT, ERR
  );

endinterface

// File: rtl/darkmemarb.sv
// Shares one external memory port between the darkriscv fetch and data ports, with
// alternating priority on ties, core stall generation and a slave-timeout watchdog.
module darkmemarb
  import darkmemarb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic        CLK,
  input  logic        RES,
  darkmemarb_if.slave bus,
  output arb_state_t  dbg_state
);

  localparam logic [ARB_CNT_W-1:0] TMO_C = ARB_CNT_W'(TMO);

  arb_state_t      state, state_n;
  arb_gnt_t        last, last_n;
  logic [ARB_CNT_W-1:0] cnt, cnt_n, cnt_inc;

  logic            m_req, m_req_n;
  logic            m_we, m_we_n;
  logic [DW/8-1:0] m_be, m_be_n;
  logic [AW-1:0]   m_addr, m_addr_n;
  logic [DW-1:0]   m_wdata, m_wdata_n;

  logic            i_ack, i_ack_n;
  logic            d_ack, d_ack_n;
  logic [DW-1:0]   i_data, i_data_n;
  logic [DW-1:0]   d_rdata, d_rdata_n;
  logic            err, err_n;

  logic            d_req;
  logic            i_pend, d_pend;
  logic            grant_i;
  logic            done;
  logic [DW-1:0]   done_data;

  assign d_req = bus.D_RD | bus.D_WR;

  // A request seen alongside its own ACK is the access just finished, not a new one.
  assign i_pend  = bus.I_REQ & ~i_ack;
  assign d_pend  = d_req & ~d_ack;
  assign cnt_inc = sat_inc(cnt);

  always_comb begin
    state_n   = state;
    last_n    = last;
    cnt_n     = cnt;
    m_req_n   = m_req;
    m_we_n    = m_we;
    m_be_n    = m_be;
    m_addr_n  = m_addr;
    m_wdata_n = m_wdata;
    i_ack_n   = 1'b0;
    d_ack_n   = 1'b0;
    i_data_n  = i_data;
    d_rdata_n = d_rdata;
    err_n     = err;
    grant_i   = 1'b0;
    done      = 1'b0;
    done_data = bus.M_RDATA;

    case (state)
      IDLE: begin
        grant_i = i_pend & (~d_pend | (last == GNT_D));
        if (grant_i) begin
          state_n  = BUSY_I;
          last_n   = GNT_I;
          cnt_n    = '0;
          m_req_n  = 1'b1;
          m_we_n   = 1'b0;
          m_be_n   = '1;
          m_addr_n = bus.I_ADDR;
        end else if (d_pend) begin
          state_n   = BUSY_D;
          last_n    = GNT_D;
          cnt_n     = '0;
          m_req_n   = 1'b1;
          m_we_n    = bus.D_WR;
          m_be_n    = bus.D_BE;
          m_addr_n  = bus.D_ADDR;
          m_wdata_n = bus.D_WDATA;
        end
      end

      BUSY_I, BUSY_D: begin
        // A real acknowledge beats a watchdog expiry in the same cycle.
        if (bus.M_ACK) begin
          done      = 1'b1;
          done_data = bus.M_RDATA;
        end else if (cnt_inc == TMO_C) begin
          done      = 1'b1;
          done_data = ARB_ABORT_DATA[DW-1:0];
          err_n     = 1'b1;
          cnt_n     = cnt_inc;
        end else begin
          cnt_n = cnt_inc;
        end

        if (done) begin
          state_n = IDLE;
          m_req_n = 1'b0;
          if (state == BUSY_I) begin
            i_ack_n  = 1'b1;
            i_data_n = done_data;
          end else begin
            d_ack_n   = 1'b1;
            d_rdata_n = done_data;
          end
        end
      end

      default: begin
        state_n = IDLE;
        m_req_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RES) begin
      state   <= IDLE;
      last    <= GNT_D;
      cnt     <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_be    <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_data  <= '0;
      d_rdata <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      last    <= last_n;
      cnt     <= cnt_n;
      m_req   <= m_req_n;
      m_we    <= m_we_n;
      m_be    <= m_be_n;
      m_addr  <= m_addr_n;
      m_wdata <= m_wdata_n;
      i_ack   <= i_ack_n;
      d_ack   <= d_ack_n;
      i_data  <= i_data_n;
      d_rdata <= d_rdata_n;
      err     <= err_n;
    end
  end

  assign bus.M_REQ   = m_req;
  assign bus.M_WE    = m_we;
  assign bus.M_BE    = m_be;
  assign bus.M_ADDR  = m_addr;
  assign bus.M_WDATA = m_wdata;
  assign bus.I_ACK   = i_ack;
  assign bus.I_DATA  = i_data;
  assign bus.D_ACK   = d_ack;
  assign bus.D_RDATA = d_rdata;
  assign bus.ERR     = err;
  assign bus.HLT     = i_pend | d_pend;
  assign dbg_state   = state;

endmodule

// File: tb/tb_darkmemarb.sv
// Directed bench for darkmemarb: a memory slave with programmable wait states, a
// requester-side data scoreboard and cycle-exact checks of the shared-port protocol.
module tb_darkmemarb;
  import darkmemarb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic       CLK = 1'b0;
  logic       RES = 1'b0;
  arb_state_t dbg_state;

  darkmemarb_if #(.AW(AW), .DW(DW)) bus ();

  darkmemarb #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .CLK       (CLK),
    .RES       (RES),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "bench timeout");
  end

  // ---------------- scoreboard state ----------------
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_i_q[$];
  logic [DW-1:0] exp_d_q[$];

  logic slave_en   = 1'b1;
  logic stray_ack  = 1'b0;
  int   slave_wait = 0;

  function automatic logic [DW-1:0] rdata_fn(input logic [AW-1:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h3C3C_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // ---------------- memory slave ----------------
  initial begin : slave
    int   wcnt;
    logic ack;
    wcnt = 0;
    bus.M_ACK   = 1'b0;
    bus.M_RDATA = '0;
    forever begin
      tick();
      ack = stray_ack;
      if (bus.M_REQ && slave_en) begin
        if (wcnt == slave_wait) begin
          ack  = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      bus.M_ACK   = ack;
      bus.M_RDATA = ack ? rdata_fn(bus.M_ADDR) : DW'($urandom);
    end
  end

  // ---------------- requester-side monitor ----------------
  initial begin : monitor
    forever begin
      smp();
      if (bus.I_ACK === 1'b1) begin
        if (exp_i_q.size() == 0) chk("i_ack_unexpected", bus.I_ACK, 64'd0);
        else chk("i_data", bus.I_DATA, exp_i_q.pop_front());
      end
      if (bus.D_ACK === 1'b1) begin
        if (exp_d_q.size() == 0) chk("d_ack_unexpected", bus.D_ACK, 64'd0);
        else chk("d_rdata", bus.D_RDATA, exp_d_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    tick();
    RES = 1'b0;
    bus.I_REQ = 1'b0;
    bus.D_RD  = 1'b0;
    bus.D_WR  = 1'b0;
    tick();
    smp();
    chk("rst_mreq",  bus.M_REQ, 64'd0);
    chk("rst_iack",  bus.I_ACK, 64'd0);
    chk("rst_dack",  bus.D_ACK, 64'd0);
    chk("rst_err",   bus.ERR,   64'd0);
    chk("rst_hlt",   bus.HLT,   64'd0);
    chk("rst_maddr", bus.M_ADDR, 64'd0);
    chk("rst_state", dbg_state, 64'(IDLE));
    tick();
    RES = 1'b1;
  endtask

  task automatic data_xfer(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int wt);
    int t;
    slave_wait = wt;
    tick();
    bus.D_RD    = ~wr;
    bus.D_WR    = wr;
    bus.D_ADDR  = addr;
    bus.D_WDATA = wdata;
    bus.D_BE    = 4'hF;
    exp_d_q.push_back(rdata_fn(addr));
    t = 0;
    smp();
    while (bus.D_ACK !== 1'b1 && t < 40) begin
      tick();
      smp();
      t++;
    end
    chk("d_xfer_latency", 64'(t), 64'(wt + 2));
    tick();
    bus.D_RD = 1'b0;
    bus.D_WR = 1'b0;
  endtask

  task automatic inst_xfer(input logic [AW-1:0] addr, input int wt);
    int t;
    slave_wait = wt;
    tick();
    bus.I_REQ  = 1'b1;
    bus.I_ADDR = addr;
    exp_i_q.push_back(rdata_fn(addr));
    t = 0;
    smp();
    while (bus.I_ACK !== 1'b1 && t < 40) begin
      tick();
      smp();
      t++;
    end
    chk("i_xfer_latency", 64'(t), 64'(wt + 2));
    tick();
    bus.I_REQ = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int   ni, nd;
    logic order_q[$];

    bus.I_REQ   = 1'b0;
    bus.I_ADDR  = '0;
    bus.D_RD    = 1'b0;
    bus.D_WR    = 1'b0;
    bus.D_BE    = '0;
    bus.D_ADDR  = '0;
    bus.D_WDATA = '0;

    do_reset();

    // Single fetch against a zero-wait slave.
    slave_en   = 1'b1;
    slave_wait = 0;
    tick();
    bus.I_REQ  = 1'b1;
    bus.I_ADDR = 32'h100;
    exp_i_q.push_back(rdata_fn(32'h100));
    smp();
    chk("f_c0_hlt",  bus.HLT,   64'd1);
    chk("f_c0_mreq", bus.M_REQ, 64'd0);
    tick(); smp();
    chk("f_c1_mreq",  bus.M_REQ,  64'd1);
    chk("f_c1_maddr", bus.M_ADDR, 64'h100);
    chk("f_c1_mwe",   bus.M_WE,   64'd0);
    chk("f_c1_mbe",   bus.M_BE,   64'hF);
    chk("f_c1_hlt",   bus.HLT,    64'd1);
    chk("f_c1_state", dbg_state,  64'(BUSY_I));
    tick(); smp();
    chk("f_c2_iack", bus.I_ACK, 64'd1);
    chk("f_c2_mreq", bus.M_REQ, 64'd0);
    chk("f_c2_hlt",  bus.HLT,   64'd0);
    tick();
    bus.I_REQ = 1'b0;
    smp();
    chk("f_c3_no_rearb", bus.M_REQ, 64'd0);
    chk("f_c3_iack",     bus.I_ACK, 64'd0);

    // Data write against a 3-wait slave.
    slave_wait = 3;
    tick();
    bus.D_WR    = 1'b1;
    bus.D_ADDR  = 32'h2004;
    bus.D_BE    = 4'b0011;
    bus.D_WDATA = 32'hDEAD_BEEF;
    exp_d_q.push_back(rdata_fn(32'h2004));
    smp();
    chk("w_c0_hlt", bus.HLT, 64'd1);
    for (int c = 1; c <= 4; c++) begin
      tick(); smp();
      chk($sformatf("w_c%0d_mreq", c),  bus.M_REQ,   64'd1);
      chk($sformatf("w_c%0d_mwe", c),   bus.M_WE,    64'd1);
      chk($sformatf("w_c%0d_mbe", c),   bus.M_BE,    64'h3);
      chk($sformatf("w_c%0d_maddr", c), bus.M_ADDR,  64'h2004);
      chk($sformatf("w_c%0d_mwdat", c), bus.M_WDATA, 64'hDEAD_BEEF);
      chk($sformatf("w_c%0d_dack", c),  bus.D_ACK,   64'd0);
    end
    tick(); smp();
    chk("w_c5_dack", bus.D_ACK, 64'd1);
    chk("w_c5_mreq", bus.M_REQ, 64'd0);
    tick();
    bus.D_WR = 1'b0;
    smp();
    chk("w_c6_mreq", bus.M_REQ, 64'd0);

    // Both ports held continuously: grants alternate starting with the fetch.
    do_reset();
    slave_wait = 0;
    exp_i_q.push_back(rdata_fn(32'h300));
    exp_i_q.push_back(rdata_fn(32'h300));
    exp_d_q.push_back(rdata_fn(32'h400));
    exp_d_q.push_back(rdata_fn(32'h400));
    tick();
    bus.I_REQ  = 1'b1;
    bus.I_ADDR = 32'h300;
    bus.D_RD   = 1'b1;
    bus.D_ADDR = 32'h400;
    bus.D_BE   = 4'hF;
    ni = 0;
    nd = 0;
    for (int c = 0; c < 30 && (ni < 2 || nd < 2); c++) begin
      smp();
      if (bus.I_ACK === 1'b1) begin ni++; order_q.push_back(1'b0); end
      if (bus.D_ACK === 1'b1) begin nd++; order_q.push_back(1'b1); end
      tick();
      if (ni >= 2) bus.I_REQ = 1'b0;
      if (nd >= 2) bus.D_RD  = 1'b0;
    end
    chk("alt_nacks", 64'(order_q.size()), 64'd4);
    for (int i = 0; i < order_q.size() && i < 4; i++)
      chk($sformatf("alt_grant%0d", i), order_q[i], 64'(i % 2));
    smp();
    chk("alt_idle_after", bus.M_REQ, 64'd0);

    // Stray M_ACK while idle is ignored.
    stray_ack = 1'b1;
    tick(); smp();
    stray_ack = 1'b0;
    tick(); smp();
    chk("stray_iack",  bus.I_ACK, 64'd0);
    chk("stray_dack",  bus.D_ACK, 64'd0);
    chk("stray_state", dbg_state, 64'(IDLE));

    // Slave never answers: abort after TMO busy cycles.
    slave_en = 1'b0;
    tick();
    bus.I_REQ  = 1'b1;
    bus.I_ADDR = 32'h500;
    exp_i_q.push_back(32'hFFFF_FFFF);
    for (int c = 1; c <= TMO; c++) begin
      tick(); smp();
      chk($sformatf("tmo_c%0d_mreq", c), bus.M_REQ, 64'd1);
      chk($sformatf("tmo_c%0d_err", c),  bus.ERR,   64'd0);
    end
    tick(); smp();
    chk("tmo_abort_mreq", bus.M_REQ, 64'd0);
    chk("tmo_abort_iack", bus.I_ACK, 64'd1);
    chk("tmo_abort_err",  bus.ERR,   64'd1);
    tick();
    bus.I_REQ = 1'b0;
    slave_en  = 1'b1;
    smp();
    chk("tmo_err_sticky", bus.ERR, 64'd1);
    data_xfer(1'b0, 32'h600, 32'h0, 1);
    smp();
    chk("tmo_err_after_xfer", bus.ERR, 64'd1);

    // M_ACK on the very cycle the watchdog would expire.
    do_reset();
    data_xfer(1'b0, 32'h700, 32'h0, TMO - 1);
    smp();
    chk("edge_tmo_err", bus.ERR, 64'd0);

    // Reset while a data access is outstanding: no ACK for the abandoned access.
    slave_en = 1'b0;
    tick();
    bus.D_RD   = 1'b1;
    bus.D_WR   = 1'b0;
    bus.D_ADDR = 32'h800;
    tick();
    tick();
    tick();
    RES = 1'b0;
    smp();
    chk("mres_c3_state", dbg_state, 64'(BUSY_D));
    tick();
    RES      = 1'b1;
    bus.D_RD = 1'b0;
    smp();
    chk("mres_c4_mreq",  bus.M_REQ, 64'd0);
    chk("mres_c4_dack",  bus.D_ACK, 64'd0);
    chk("mres_c4_state", dbg_state, 64'(IDLE));
    slave_en = 1'b1;
    tick(); smp();
    chk("mres_c5_dack", bus.D_ACK, 64'd0);
    inst_xfer(32'h900, 0);
    smp();
    chk("mres_err", bus.ERR, 64'd0);

    // A few randomised single transactions on both ports.
    for (int i = 0; i < 6; i++) begin
      data_xfer(1'($urandom_range(0, 1)), AW'($urandom_range(0, 16'hFFFF)) << 2,
                DW'($urandom), $urandom_range(0, 4));
      inst_xfer(AW'($urandom_range(0, 16'hFFFF)) << 2, $urandom_range(0, 4));
    end

    tick(); smp();
    tick(); smp();
    chk("i_queue_drained", 64'(exp_i_q.size()), 64'd0);
    chk("d_queue_drained", 64'(exp_d_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/darkmemarb.md
# darkmemarb

Two-port to one-port memory arbiter for the darkriscv SoC. It shares a single external memory port (the external RAM or flash AXI-side adapter) between the core's instruction-fetch port and data port. It sequences each access as a request/acknowledge transaction and generates the core `HLT` stall. A timeout watchdog reports a non-responding slave.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (byte enables are `DW/8` bits)
- `TMO`, 255, cycles without `M_ACK` before a transaction is aborted (1..65535)

Ports:
- `CLK`  in  1  single clock; all logic on the rising edge
- `RES`  in  1  reset; synchronous, active-low (0 = reset)
- `I_REQ`  in  1  instruction fetch request
- `I_ADDR`  in  AW  fetch address
- `I_DATA`  out  DW  fetched word, valid when `I_ACK`=1
- `I_ACK`  out  1  one-cycle fetch completion pulse
- `D_RD`, `D_WR`  in  1  data read / write request (never both high)
- `D_BE`  in  DW/8  write byte enables
- `D_ADDR`  in  AW  data address
- `D_WDATA`  in  DW  write data
- `D_RDATA`  out  DW  read data, valid when `D_ACK`=1
- `D_ACK`  out  1  one-cycle data completion pulse
- `M_REQ`  out  1  shared-port request, held until `M_ACK` or abort
- `M_WE`, `M_BE`, `M_ADDR`, `M_WDATA`  out  1/DW/8/AW/DW  shared-port command, stable while `M_REQ`=1
- `M_RDATA`  in  DW  slave read data, sampled when `M_ACK`=1
- `M_ACK`  in  1  slave completion
- `HLT`  out  1  core stall
- `ERR`  out  1  sticky timeout flag

## Operation
- States are `IDLE`, `BUSY_I` and `BUSY_D`.
- **From `IDLE`:**
  - A pending data request (`D_RD|D_WR`) alone goes to `BUSY_D`.
  - A pending `I_REQ` alone goes to `BUSY_I`.
  - When both are pending, the port not granted last wins (alternation). The last-grant register resets to "data", so instruction wins the first tie.
- **On entry to `BUSY_x`:**
  - Register `M_ADDR`, `M_WE`, `M_BE` and `M_WDATA` from the granted requester and set `M_REQ`=1.
  - Instruction grants drive `M_WE`=0 and `M_BE`=all ones.
- **In `BUSY_x` with `M_ACK`=1:**
  - Capture `M_RDATA` into `I_DATA` or `D_RDATA`.
  - Pulse the matching ACK on the next cycle, clear `M_REQ` and return to `IDLE`.
  - Writes also capture `M_RDATA`; its value is don't-care.
- **Timeout:**
  - A counter clears on grant and increments each `BUSY` cycle without `M_ACK`.
  - When it reaches `TMO`, abort: clear `M_REQ`, pulse the requester ACK with all-ones data, set `ERR` and go to `IDLE`.
  - `ERR` clears only on reset.
- **Requester rules:**
  - Requests and addresses are held until ACK.
  - A requester dropping its request mid-transaction is ignored: the transaction completes and the ACK is still pulsed.
  - A request still high in the cycle its ACK pulses is not re-arbitrated; that is the same access being released.
- `HLT` = `(I_REQ & ~I_ACK) | ((D_RD|D_WR) & ~D_ACK)`, combinational.

## Timing
- **Reset values:**
  - All outputs are 0, with `HLT` following its formula (0 when inputs are idle).
  - State is `IDLE`, the timeout counter is 0 and the last grant is data.
- **Latency:** a request seen in `IDLE` at cycle 0 gives `M_REQ`=1 at cycle 1. `M_ACK` at cycle n (n≥1) gives requester ACK and data at cycle n+1, with `M_REQ`=0 at n+1. Minimum latency is 2 cycles.
- **Throughput:** the arbiter samples new requests in the ACK cycle (n+1) while in `IDLE`. A held back-to-back request is therefore granted at n+2 earliest, giving one bubble per transaction.
- **`M_ACK` outside `BUSY`:** ignored.
- **`M_ACK` coincident with timeout expiry:** `M_ACK` wins and the real data is delivered, with no `ERR`.
- **Reset asserted mid-transaction:** `M_REQ` and all ACKs are 0 on the next edge. No ACK is issued for the abandoned access.
- **Counter width:** 16 bits, saturating, never wraps.

## Structure
- Package `darkmemarb_pkg` holds:
  - the state enum `arb_state_t` (`IDLE`, `BUSY_I`, `BUSY_D`);
  - the grant typedef `arb_gnt_t` (`GNT_I`, `GNT_D`);
  - the abort data constant `ARB_ABORT_DATA` = all ones.
- Single module with no sub-module; the watchdog is an inline counter.

## Test plan
- **Single fetch, zero-wait slave** (`M_ACK`=1 whenever `M_REQ`): `I_REQ` at cycle 0 with `I_ADDR`=0x100 → `M_REQ` at 1 with `M_ADDR`=0x100; `I_ACK` at 2 with `I_DATA`=`M_RDATA`; `HLT` high cycles 0-1.
- **Data write, 3-wait slave:** `D_WR`, `D_ADDR`=0x2004, `D_BE`=0b0011, `D_WDATA`=0xDEADBEEF → `M_WE`=1 and `M_BE`=0b0011 held cycles 1-4; `D_ACK` at 5.
- **Simultaneous I/D requests held continuously:** grants alternate I, D, I, D.
- **Slave never acks, `TMO`=8:** `M_REQ` drops after 8 busy cycles; requester ACK with 0xFFFFFFFF; `ERR`=1 until reset.
- **Reset during `BUSY_D` (cycle 3):** `M_REQ`=0 and `D_ACK`=0 at cycle 4; the following `I_REQ` completes normally and `ERR`=0.
- **`M_ACK` on the exact timeout cycle:** real data is delivered and `ERR` stays 0.
